// File: rtl/led_scan_driver.sv
// led_scan_driver: row-scanning 74HC595 serial driver for an 8x8 LED matrix
module led_scan_driver #(
  parameter int DIV = 4,
  parameter int HOLD = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pixel,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       sdata,
  output logic       sclk,
  output logic       latch,
  output logic [7:0] row_n,
  output logic       frame_done
);
  localparam int PW = $clog2(2 * DIV);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [PW-1:0] P_RISE = PW'(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(2 * DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD - 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_HOLD} state_t;
  state_t state, state_d;
  logic [PW-1:0] p, p_d;
  logic [HW-1:0] h, h_d;
  logic [2:0] x_d, y_d;
  logic sdata_d, sclk_d, latch_d, fd_d;
  logic [7:0] row_n_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      p <= '0;
      h <= '0;
      x <= 3'd7;
      y <= 3'd0;
      sdata <= 1'b0;
      sclk <= 1'b0;
      latch <= 1'b0;
      row_n <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      state <= state_d;
      p <= p_d;
      h <= h_d;
      x <= x_d;
      y <= y_d;
      sdata <= sdata_d;
      sclk <= sclk_d;
      latch <= latch_d;
      row_n <= row_n_d;
      frame_done <= fd_d;
    end
  end
  // Outputs are registered next-values, so each lags the state that produced it by one clock.
  always_comb begin
    state_d = state;
    p_d = p;
    h_d = h;
    x_d = x;
    y_d = y;
    sdata_d = 1'b0;
    sclk_d = 1'b0;
    latch_d = 1'b0;
    row_n_d = 8'hFF;
    fd_d = 1'b0;
    case (state)
      S_IDLE: begin
        x_d = 3'd7;
        p_d = '0;
        state_d = enable ? S_SHIFT : S_IDLE;
      end
      S_SHIFT: begin
        p_d = p + PW'(1);
        sdata_d = (p == '0) ? pixel : sdata;
        sclk_d = (p == P_RISE) ? 1'b1 : ((p == '0) || (p == P_LAST && x == 3'd0)) ? 1'b0 : sclk;
        if (p == P_LAST) begin
          p_d = '0;
          x_d = (x != 3'd0) ? x - 3'd1 : x;
          state_d = (x != 3'd0) ? S_SHIFT : S_LATCH;
        end
      end
      S_LATCH: begin
        latch_d = 1'b1;
        h_d = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        row_n_d = ~(8'd1 << y);
        h_d = h + HW'(1);
        if (h == H_LAST) begin
          h_d = '0;
          p_d = '0;
          x_d = 3'd7;
          y_d = y + 3'd1;
          fd_d = (y == 3'd7);
          state_d = enable ? S_SHIFT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_led_scan_driver.sv
// tb_led_scan_driver: directed scenarios over random matrices, checked against a shift-register/row-timing model
module tb_led_scan_driver;
  logic clk, reset, enable, pixel, sdata, sclk, latch, frame_done;
  logic [2:0] x, y;
  logic [7:0] row_n;
  logic [7:0] mat [8];
  logic [7:0] sr = 8'h00;
  logic sclk_q = 1'b0;
  int cyc = 0, rises = 0, fd_cnt = 0;
  int vecs = 0, errs = 0;
  int last_lat = -1, fd_prev = -1, t0 = 0, n = 0;

  led_scan_driver #(.DIV(2), .HOLD(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pixel(pixel), .x(x), .y(y),
    .sdata(sdata), .sclk(sclk), .latch(latch), .row_n(row_n), .frame_done(frame_done)
  );

  assign pixel = mat[y][x];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External 74HC595 model: shifts sdata on each sclk rise, MSB first.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    sclk_q <= sclk;
    if (sclk && !sclk_q) sr <= {sr[6:0], sdata};
    if (reset || latch) rises <= 0;
    else if (sclk && !sclk_q) rises <= rises + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_latch();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (latch !== 1'b1 && k < 300);
    chk("latch_seen", latch, 1'b1);
  endtask

  // One row: latched byte must equal the matrix row, then HOLD clocks of that row's drive.
  task automatic expect_row(input int r);
    logic [7:0] act;
    act = ~(8'd1 << r);
    wait_latch();
    chk("latch_data", sr, mat[r]);
    chk("bit_count", rises, 8);
    chk("latch_row", y, r);
    if (last_lat >= 0) chk("row_period", cyc - last_lat, 37);
    last_lat = cyc;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("latch_width", latch, 1'b0);
      chk("row_drive", row_n, (k < 5) ? act : 8'hFF);
      chk("frame_done", frame_done, (r == 7 && k == 4));
      if (r == 7 && k == 4) begin
        chk("wrap_y", y, 3'd0);
        if (fd_prev >= 0) chk("frame_period", cyc - fd_prev, 296);
        fd_prev = cyc;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) mat[i] = 8'($urandom);
    mat[0] = 8'b1010_0110;
    repeat (3) @(negedge clk);
    chk("rst_x", x, 3'd7);
    chk("rst_y", y, 3'd0);
    chk("rst_row_n", row_n, 8'hFF);
    chk("rst_outs", {sclk, latch, sdata, frame_done}, 4'b0);
    reset = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; if (n == 1) t0 = cyc; end while (sclk !== 1'b1 && n < 20);
    chk("first_sclk", n, 4);
    fd_prev = t0;
    for (int r = 0; r < 8; r++) begin
      expect_row(r);
      mat[r] = 8'd1 << r;
    end
    for (int r = 0; r < 8; r++) begin
      expect_row(r);
      mat[r] = 8'($urandom);
    end
    for (int r = 0; r < 4; r++) begin
      expect_row(r);
      mat[r] = 8'($urandom);
      if (r == 2) begin
        repeat (12) @(negedge clk);
        enable = 1'b0;
      end
    end
    repeat (40) @(negedge clk);
    chk("idle_y", y, 3'd4);
    chk("idle_x", x, 3'd7);
    chk("idle_row_n", row_n, 8'hFF);
    chk("idle_no_shift", rises, 0);
    enable = 1'b1;
    last_lat = -1;
    fd_prev = -1;
    for (int r = 4; r < 8; r++) begin
      expect_row(r);
      mat[r] = 8'($urandom);
    end
    for (int r = 0; r < 5; r++) expect_row(r);
    wait_latch();
    chk("hold_row5", y, 3'd5);
    repeat (2) @(negedge clk);
    chk("hold_active", row_n, 8'hDF);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_row_n", row_n, 8'hFF);
    chk("midrst_y", y, 3'd0);
    chk("midrst_x", x, 3'd7);
    chk("midrst_pulses", {latch, frame_done, sclk, sdata}, 4'b0);
    @(negedge clk);
    reset = 1'b0;
    last_lat = -1;
    fd_prev = -1;
    for (int r = 0; r < 8; r++) expect_row(r);
    chk("fd_count", fd_cnt, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
